viterbi_traceback_ctrl: RTL
===========================

# viterbi_traceback_ctrl

Sequencing controller for the Viterbi decoder back end. It buffers N trellis columns of survivor history and path metrics from the add-compare-select stage. It then finds the minimum-error end state serially, one state per cycle, and walks the history table backwards from that state. The N decoded symbols are streamed out oldest first over a valid/ready handshake. It replaces free-running combinational min-find and traceback with a deterministic, cycle-accurate schedule.

## Interface

- `N`, default 8: traceback depth in trellis columns; legal range 2..16.
- `MW`, default 4: path-metric width in bits.

- `clk`  input  1  sole clock; all logic updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  column on `in_metric`/`in_hist` is valid.
- `in_ready`  output  1  controller accepts a column this cycle.
- `in_metric`  input  8*MW  accumulated error per state; state s in bits [s*MW +: MW].
- `in_hist`  input  24  predecessor state per state; state s in bits [s*3 +: 3].
- `out_valid`  output  1  `out_bit` is valid.
- `out_ready`  input  1  downstream accepts `out_bit`.
- `out_bit`  output  1  decoded symbol.
- `out_last`  output  1  marks the final (N-th) symbol of a block.
- `busy`  output  1  high in FIND, TRACE and EMIT.

## Operation

- **States:** FILL, FIND, TRACE, EMIT. Reset enters FILL.
- **FILL**
  - `in_ready` = 1.
  - Each handshake (`in_valid & in_ready`) writes `in_hist` into history column `col` and increments `col` (width clog2(N)).
  - The metrics are registered only when `col` = N-1.
  - The handshake at `col` = N-1 moves to FIND and clears `col`.
- **FIND: exactly 8 cycles, index k = 0..7.**
  - k=0 loads best = metric[0] and best_state = 0.
  - k=1..7 replaces best/best_state only when metric[k] < best (strict, unsigned).
  - Ties therefore resolve to the lowest state index.
- **TRACE: exactly N-1 cycles.**
  - Entry sets cur = best_state and tb[N-1] = best_state.
  - Cycle m (m = 0..N-2) computes j = N-2-m, then tb[j] = hist[j+1][cur] and cur = tb[j].
  - Column-0 history is never read.
- **Decode rule:** sym[j] = tb[j][2], i.e. 1 when the state is ≥ 4.
- **EMIT**
  - `out_valid` = 1, `out_bit` = sym[e] for e = 0..N-1, and `out_last` = (e == N-1).
  - e advances on `out_valid & out_ready`.
  - The handshake with `out_last` returns to FILL.
- **Ignored inputs:**
  - `in_valid` outside FILL has no effect; `in_ready` = 0 there.
  - `out_ready` outside EMIT has no effect.
- **Reset mid-operation:** abandons the current block and discards buffered columns; no partial output is emitted.

## Timing

- **Reset values:** `in_ready` = 0 during the reset cycle, then 1 from the first cycle after `rst` falls. `out_valid`, `out_bit`, `out_last` = 0 and `busy` = 0. `col`, e and best_state = 0.
- **Outputs are registered:** all are functions of state registers only, with no combinational input-to-output path.
- **Latency:** last FILL handshake at edge t.
  - FIND occupies cycles t+1..t+8.
  - TRACE occupies cycles t+9..t+N+7.
  - First `out_valid` occurs at cycle t+N+8 (t+16 for N=8).
- **Output stability:** `out_valid`/`out_bit`/`out_last` hold stable while `out_ready` = 0. `out_bit` does not change until a handshake occurs.
- **Return to FILL:** `in_ready` rises the cycle after the last-symbol handshake. With `out_ready` tied high, a block takes N + 8 + (N-1) + N cycles.
- **Input gaps:** gaps in `in_valid` during FILL only stall `col`; partial columns are retained indefinitely.

## Test plan

- **Single-bit result:** N=8, `in_hist` all 0. Final-column metrics {9,9,9,9,9,2,9,9}, so best_state = 5. Required bits in order: 0,0,0,0,0,0,0,1. `out_last` only on beat 8.
- **All-tie metrics:** final-column metrics all 7 and `in_hist` all 0 → best_state 0, eight 0 bits. Confirms the lowest-index tie rule.
- **Alternating chain:** every column has hist[4] = 0 and hist[0] = 4. The minimum metric is at state 4. Required bits: 0,1,0,1,0,1,0,1.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles at beat 3.
  - `out_bit`/`out_last` stay frozen for those cycles.
  - `in_ready` stays 0 and `busy` stays 1.
  - Total symbols = 8 with no duplicates.
- **Reset mid-TRACE:** assert `rst` for one cycle during TRACE.
  - Next cycle all outputs are at their reset values.
  - `in_ready` = 1 one cycle after `rst` deasserts.
  - A fresh block then decodes correctly with no stale bits.
- **Latency with input gaps:** feed 8 columns with random `in_valid` gaps. First `out_valid` must occur exactly 16 cycles after the 8th handshake, and `in_valid` pulses during FIND are ignored.

Source files
------------

// File: rtl/viterbi_traceback_ctrl_if.sv
// Column-in / symbol-out handshake bundle for the Viterbi traceback controller.
// The slave modport is the controller; the master modport is its environment.
interface viterbi_traceback_ctrl_if #(
  parameter int MW = 4
) ();
  logic          in_valid;
  logic          in_ready;
  logic [8*MW-1:0] in_metric;
  logic [23:0]   in_hist;
  logic          out_valid;
  logic          out_ready;
  logic          out_bit;
  logic          out_last;

  modport master (
    output in_valid, in_metric, in_hist, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_metric, in_hist, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/viterbi_traceback_ctrl.sv
// Buffers N trellis columns, finds the best end state serially over 8 cycles,
// walks survivor history backwards and streams the decoded bits oldest first.
module viterbi_traceback_ctrl #(
  parameter int N  = 8,
  parameter int MW = 4
) (
  input  logic clk,
  input  logic rst,
  viterbi_traceback_ctrl_if.slave bus,
  output logic busy
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST_POS = PW'(N - 1);
  localparam logic [PW-1:0] FIRST_J  = PW'(N - 2);

  typedef enum logic [1:0] {FILL, FIND, TRACE, EMIT} state_t;

  state_t state, state_next;

  logic [PW-1:0] col;
  logic [PW-1:0] pos;
  logic [2:0]    k;
  logic [2:0]    cur;
  logic [2:0]    best_state;
  logic [2:0]    final_state;
  logic [2:0]    next_cur;
  logic [MW-1:0] best;
  logic [MW-1:0] metric [8];
  logic [2:0]    hist [N][8];
  logic [N-1:0]  sym;
  logic          in_ready_q;
  logic          in_fire;

  assign bus.in_ready = in_ready_q;
  assign in_fire      = bus.in_valid & in_ready_q;

  // The k=7 compare and the traceback start must agree in the same edge.
  assign final_state = (metric[7] < best) ? 3'd7 : best_state;
  assign next_cur    = hist[pos + PW'(1)][cur];

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_bit   = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      FILL: begin
        if (in_fire && col == LAST_POS) state_next = FIND;
      end
      FIND: begin
        busy = 1'b1;
        if (k == 3'd7) state_next = TRACE;
      end
      TRACE: begin
        busy = 1'b1;
        if (pos == '0) state_next = EMIT;
      end
      EMIT: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_bit   = sym[pos];
        bus.out_last  = (pos == LAST_POS);
        if (bus.out_ready && pos == LAST_POS) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // Column storage needs no reset: col is cleared, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int s = 0; s < 8; s++) hist[col][s] <= bus.in_hist[s*3 +: 3];
      if (col == LAST_POS) begin
        for (int s = 0; s < 8; s++) metric[s] <= bus.in_metric[s*MW +: MW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      pos        <= '0;
      k          <= '0;
      cur        <= '0;
      best       <= '0;
      best_state <= '0;
      sym        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (state_next == FILL);
      case (state)
        FILL: begin
          if (in_fire) begin
            if (col == LAST_POS) begin
              col <= '0;
              k   <= '0;
            end else begin
              col <= col + PW'(1);
            end
          end
        end
        FIND: begin
          if (k == 3'd0) begin
            best       <= metric[0];
            best_state <= 3'd0;
          end else if (metric[k] < best) begin
            best       <= metric[k];
            best_state <= k;
          end
          k <= k + 3'd1;
          if (k == 3'd7) begin
            cur        <= final_state;
            sym[N-1]   <= final_state[2];
            pos        <= FIRST_J;
          end
        end
        TRACE: begin
          sym[pos] <= next_cur[2];
          cur      <= next_cur;
          if (pos != '0) pos <= pos - PW'(1);
        end
        EMIT: begin
          if (bus.out_ready) pos <= (pos == LAST_POS) ? '0 : pos + PW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
